// File: rtl/lif_spike_rate_meter.sv
// lif_spike_rate_meter
//   Watches the spike level coming out of a LIF neuron. Over a window of
//   2^WINDOW_LOG2 enabled cycles it counts spike events (rising edges) and
//   tracks the minimum and most recent inter-spike interval. At each window
//   close a record is offered on a valid/ready interface.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active high
//   en           : count enable; low freezes window/ISI counters, drops events
//   spike_in     : spike level from the neuron (may be held for several cycles)
//   rate_out     : spike count of the last closed window (saturating)
//   isi_min_out  : minimum ISI in that window, all-ones if no interval
//   isi_last_out : most recent ISI at the time the record was captured
//   out_valid    : record available
//   out_ready    : consumer accepts when out_valid & out_ready
//   overrun      : sticky, a window closed while a record was still unaccepted
//   clear        : synchronous clear of overrun (a same-cycle set wins)
module lif_spike_rate_meter #(
  parameter int WINDOW_LOG2 = 8,
  parameter int CNT_W       = 8,
  parameter int ISI_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_in,
  output logic [CNT_W-1:0] rate_out,
  output logic [ISI_W-1:0] isi_min_out,
  output logic [ISI_W-1:0] isi_last_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clear
);

  logic                   r_spike_d;
  logic [WINDOW_LOG2-1:0] r_win_cnt;
  logic [CNT_W-1:0]       r_spk_cnt;
  logic [ISI_W-1:0]       r_isi_cnt;
  logic [ISI_W-1:0]       r_min;
  logic [ISI_W-1:0]       r_last;
  logic                   r_have_prev;
  logic [CNT_W-1:0]       r_rate;
  logic [ISI_W-1:0]       r_isi_min;
  logic [ISI_W-1:0]       r_isi_last;
  logic                   r_valid;
  logic                   r_overrun;

  logic                   w_evt;
  logic                   w_close;
  logic                   w_has_ival;
  logic [ISI_W-1:0]       w_ival;
  logic [CNT_W-1:0]       w_cnt_rec;
  logic [ISI_W-1:0]       w_min_rec;
  logic [ISI_W-1:0]       w_last_rec;
  logic                   w_load;

  // Rising edge of the spike level, gated by enable.
  assign w_evt      = spike_in & ~r_spike_d & en;
  assign w_close    = en & (r_win_cnt == {WINDOW_LOG2{1'b1}});
  assign w_has_ival = w_evt & r_have_prev;

  // Interval = cycles since the previous event, i.e. counter + 1; the
  // saturated counter maps to all-ones (overflow).
  assign w_ival = (r_isi_cnt == {ISI_W{1'b1}}) ? {ISI_W{1'b1}} : r_isi_cnt + 1'b1;

  // Values as they stand including anything happening this cycle; these feed
  // both the running state and the record captured on close.
  assign w_cnt_rec  = (w_evt && (r_spk_cnt != {CNT_W{1'b1}})) ? r_spk_cnt + 1'b1 : r_spk_cnt;
  assign w_min_rec  = (w_has_ival && (w_ival < r_min)) ? w_ival : r_min;
  assign w_last_rec = w_has_ival ? w_ival : r_last;

  // A new record is taken if the slot is free or being drained this cycle.
  assign w_load = w_close & (~r_valid | out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spike_d   <= 1'b0;
      r_win_cnt   <= '0;
      r_spk_cnt   <= '0;
      r_isi_cnt   <= '0;
      r_min       <= '1;
      r_last      <= '0;
      r_have_prev <= 1'b0;
      r_rate      <= '0;
      r_isi_min   <= '0;
      r_isi_last  <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_spike_d <= spike_in;

      if (en)
        r_win_cnt <= r_win_cnt + 1'b1;

      if (w_close)
        r_spk_cnt <= '0;
      else
        r_spk_cnt <= w_cnt_rec;

      if (w_evt)
        r_isi_cnt <= '0;
      else if (en && (r_isi_cnt != {ISI_W{1'b1}}))
        r_isi_cnt <= r_isi_cnt + 1'b1;

      if (w_evt)
        r_have_prev <= 1'b1;

      // Running min restarts per window; last interval persists across windows.
      if (w_close)
        r_min <= '1;
      else
        r_min <= w_min_rec;
      r_last <= w_last_rec;

      if (w_load) begin
        r_rate     <= w_cnt_rec;
        r_isi_min  <= w_min_rec;
        r_isi_last <= w_last_rec;
        r_valid    <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end

      if (w_close && !w_load)
        r_overrun <= 1'b1;
      else if (clear)
        r_overrun <= 1'b0;
    end
  end

  assign rate_out     = r_rate;
  assign isi_min_out  = r_isi_min;
  assign isi_last_out = r_isi_last;
  assign out_valid    = r_valid;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_lif_spike_rate_meter.sv
module tb_lif_spike_rate_meter;

  localparam int WL2 = 4;
  localparam int WIN = 16;
  localparam int SAT = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       spike_in = 1'b0;
  logic       out_ready = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] rate_out, isi_min_out, isi_last_out;
  logic       out_valid, overrun;

  int n_total = 0;
  int n_pass  = 0;

  lif_spike_rate_meter #(.WINDOW_LOG2(WL2), .CNT_W(8), .ISI_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .rate_out(rate_out), .isi_min_out(isi_min_out), .isi_last_out(isi_last_out),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun), .clear(clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Time is measured in enabled cycles (n). Events are remembered by the
  // enabled-cycle index at which they happened; an interval is simply the
  // difference of two indices, clipped to all-ones.
  int n = 0, lastevt = -1, wcnt = 0, wmin = SAT, mlast = 0;
  int m_rate = 0, m_min = 0, m_last = 0, iv = 0;
  bit mvalid = 0, movr = 0, mspk_d = 0, mevt = 0, mclose = 0, mload = 0, mset = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      n = 0; lastevt = -1; wcnt = 0; wmin = SAT; mlast = 0;
      m_rate = 0; m_min = 0; m_last = 0; mvalid = 0; movr = 0; mspk_d = 0;
    end else begin
      mevt = spike_in && !mspk_d && en;
      mspk_d = spike_in;
      if (mevt) begin
        if (lastevt >= 0) begin
          iv = n - lastevt;
          if (iv > SAT) iv = SAT;
          if (iv < wmin) wmin = iv;
          mlast = iv;
        end
        lastevt = n;
        if (wcnt < SAT) wcnt++;
      end
      mclose = en && (n % WIN == WIN - 1);
      mload = 0; mset = 0;
      if (mclose) begin
        if (!mvalid || out_ready) begin
          mload = 1; m_rate = wcnt; m_min = wmin; m_last = mlast;
        end else mset = 1;
        wcnt = 0; wmin = SAT;
      end
      if (mset) movr = 1;
      else if (clear) movr = 0;
      if (mload) mvalid = 1;
      else if (mvalid && out_ready) mvalid = 0;
      if (en) n++;
    end
  end

  // Compare every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("m_valid",   out_valid,    mvalid);
    chk("m_overrun", overrun,      movr);
    chk("m_rate",    rate_out,     m_rate);
    chk("m_isi_min", isi_min_out,  m_min);
    chk("m_isi_last",isi_last_out, m_last);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic e, input logic s, input logic r, input logic c);
    en = e; spike_in = s; out_ready = r; clear = c;
    @(negedge clk);
  endtask

  task automatic do_reset();
    en = 0; spike_in = 0; out_ready = 0; clear = 0;
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic rec(input string nm, input int v, input int r, input int mn, input int ls);
    chk({nm, "_valid"}, out_valid, v);
    chk({nm, "_rate"}, rate_out, r);
    chk({nm, "_min"}, isi_min_out, mn);
    chk({nm, "_last"}, isi_last_out, ls);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    rec("rst0", 0, 0, 0, 0);
    chk("rst0_ovr", overrun, 0);

    // 1: spike every 4 cycles, ready high
    for (int i = 0; i < 3 * WIN; i++) begin
      cyc(1, (i % 4) == 0, 1, 0);
      if (i % WIN == WIN - 1) rec("s1", 1, 4, 4, 4);
      else if (i % WIN == 0 && i > 0) chk("s1_vlow", out_valid, 0);
    end

    // 2: silence for 3 windows after reset
    do_reset();
    for (int i = 0; i < 3 * WIN; i++) begin
      cyc(1, 0, 1, 0);
      if (i % WIN == WIN - 1) begin
        rec("s2", 1, 0, SAT, 0);
        chk("s2_ovr", overrun, 0);
      end
    end

    // 3: backpressure, overrun, clear, set-beats-clear
    for (int i = 0; i < WIN; i++) cyc(1, (i == 2) || (i == 7), i == 0, 0);
    rec("s3a", 1, 2, 5, 5);
    chk("s3a_ovr", overrun, 0);
    for (int i = 0; i < WIN; i++) cyc(1, 0, 0, 0);
    rec("s3b", 1, 2, 5, 5);
    chk("s3b_ovr", overrun, 1);
    for (int i = 0; i < WIN; i++) begin
      cyc(1, 0, i == 0, i == 1);
      if (i == 0) chk("s3c_vdrop", out_valid, 0);
      if (i == 1) chk("s3c_clr", overrun, 0);
    end
    rec("s3c", 1, 0, SAT, 5);
    for (int i = 0; i < WIN; i++) cyc(1, 0, 0, i == WIN - 1);
    chk("s3d_setwins", overrun, 1);
    rec("s3d", 1, 0, SAT, 5);
    for (int i = 0; i < WIN; i++) cyc(1, 0, 1, i == 0);
    chk("s3e_ovr", overrun, 0);

    // 4: held level counts once; same pulse with en low is ignored
    for (int i = 0; i < WIN; i++) cyc(1, (i >= 3) && (i <= 12), 1, 0);
    rec("s4a", 1, 1, 76, 76);
    for (int i = 0; i < WIN; i++) begin
      cyc(1, (i == 1) || (i == 5), 1, 0);
      if (i == 2) begin
        for (int j = 0; j < 12; j++) begin
          cyc(0, j < 10, 1, 0);
          chk("s4_frozen_v", out_valid, 0);
        end
      end
    end
    rec("s4b", 1, 2, 4, 4);

    // 5: event on the close cycle belongs to the closing window
    for (int i = 0; i < WIN; i++) cyc(1, (i == 13) || (i == 15), 1, 0);
    rec("s5a", 1, 2, 2, 2);
    for (int i = 0; i < WIN; i++) cyc(1, 0, 1, 0);
    rec("s5b", 1, 0, SAT, 2);

    // 6: asynchronous reset mid-window
    for (int i = 0; i < 8; i++) cyc(1, (i == 1) || (i == 3) || (i == 5), 0, 0);
    rec("s6pre", 1, 0, SAT, 2);
    #2 rst = 1;
    #1;
    rec("s6async", 0, 0, 0, 0);
    chk("s6async_ovr", overrun, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < WIN; i++) cyc(1, (i == 2) || (i == 7), 1, 0);
    rec("s6", 1, 2, 5, 5);

    cyc(1, 0, 1, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
